mmcm_drp_responder: RTL

Behavioural DRP responder for the MMCM reconfiguration port: the responding end of the register-driven DRP initiator used for clock reconfiguration. It accepts DRP read/write strobes, services them from a 128 x 16 register file after a fixed latency, returns a one-cycle ready pulse, and models the MMCM lock response to DRP writes and to DRP reset. It is instantiated in place of the MMCM primitive in simulation and in loopback test builds, which lets the host-side DRP software path be exercised without real clock hardware.

---
 rtl/mmcm_drp_responder.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mmcm_drp_responder.sv
// Behavioural stand-in for the MMCM DRP port: a 128 x 16 register file answered
// after a fixed latency, plus a simple lock model driven by DRP writes and drp_reset.
//
// state | meaning
// IDLE  | waiting for drp_den
// WAIT  | transaction accepted, latency counter running
// RESP  | drp_drdy high for this one cycle
module mmcm_drp_responder #(
    parameter int unsigned pLATENCY     = 4,
    parameter int unsigned pLOCK_CYCLES = 16,
    parameter logic [15:0] pINIT        = 16'h0000
) (
    input  logic        clk_usb,
    input  logic        reset_n,
    input  logic [6:0]  drp_addr,
    input  logic        drp_den,
    input  logic [15:0] drp_din,
    input  logic        drp_dwe,
    output logic [15:0] drp_dout,
    output logic        drp_drdy,
    input  logic        drp_reset,
    output logic        locked,
    output logic        busy,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(pLATENCY - 1);
    localparam logic [7:0] LOCK_TC  = 8'(pLOCK_CYCLES);
    localparam logic       LAT1     = (pLATENCY == 1);

    state_t      state;
    logic [3:0]  cnt;
    logic [6:0]  addr_q;
    logic [15:0] din_q;
    logic        dwe_q;
    logic [15:0] mem [128];
    logic [7:0]  lock_cnt;
    logic        count_en;

    logic        accept;
    logic        enter_resp;
    logic        write_done;
    logic [6:0]  tgt_addr;
    logic [15:0] tgt_din;
    logic        tgt_we;

    assign accept     = (state == IDLE) && drp_den;
    assign enter_resp = (accept && LAT1) || ((state == WAIT) && (cnt == 4'd1));
    // With a latency of one the completing edge is also the capture edge.
    assign tgt_addr   = accept ? drp_addr : addr_q;
    assign tgt_din    = accept ? drp_din  : din_q;
    assign tgt_we     = accept ? drp_dwe  : dwe_q;
    assign write_done = enter_resp && tgt_we;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            addr_q   <= 7'd0;
            din_q    <= 16'd0;
            dwe_q    <= 1'b0;
            drp_drdy <= 1'b0;
            drp_dout <= 16'd0;
            err      <= 1'b0;
        end else begin
            drp_drdy <= 1'b0;
            if (drp_den && (state != IDLE))
                err <= 1'b1;
            case (state)
                IDLE: begin
                    if (drp_den) begin
                        addr_q <= drp_addr;
                        din_q  <= drp_din;
                        dwe_q  <= drp_dwe;
                        cnt    <= CNT_LOAD;
                        state  <= LAT1 ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1)
                        state <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
            if (enter_resp) begin
                drp_drdy <= 1'b1;
                if (!tgt_we)
                    drp_dout <= mem[tgt_addr];
            end
        end
    end

    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 128; i++)
                mem[i] <= pINIT;
        end else if (write_done) begin
            mem[tgt_addr] <= tgt_din;
        end
    end

    // drp_reset outranks a completing write so a same-cycle reset re-arms the counter.
    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            lock_cnt <= 8'd0;
            locked   <= 1'b0;
            count_en <= 1'b1;
        end else if (drp_reset) begin
            lock_cnt <= 8'd0;
            locked   <= 1'b0;
            count_en <= 1'b1;
        end else if (write_done) begin
            lock_cnt <= 8'd0;
            locked   <= 1'b0;
            count_en <= 1'b0;
        end else if (count_en && !locked) begin
            lock_cnt <= lock_cnt + 8'd1;
            if (lock_cnt + 8'd1 == LOCK_TC)
                locked <= 1'b1;
        end
    end
endmodule
